// File: rtl/freq_meter.sv
// freq_meter: measures the period of a slow, possibly asynchronous signal in CLK cycles.
// Optional build macro FREQ_METER_AVG4_EN: average the result over four consecutive periods.
module freq_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             busy,
  output logic             overflow
);

`ifdef FREQ_METER_AVG4_EN
  localparam int ACC_W = CNT_W + 2;
`else
  localparam int ACC_W = CNT_W;
`endif

  localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_TOP = ACC_MAX - ACC_ONE;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;
  logic                   rise;
  logic                   last_edge;
  logic [CNT_W-1:0]       result;

`ifdef FREQ_METER_AVG4_EN
  logic [1:0]             edg_q, edg_d;
`endif

  // Synchroniser shift chain and rising-edge detect on the synchronised signal
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    s_prev_d = sync_q[SYNC_STAGES-1];
    rise     = sync_q[SYNC_STAGES-1] & ~s_prev_q;
  end

  // Decide whether the current rise closes the measurement, and the value it yields
  always_comb begin
`ifdef FREQ_METER_AVG4_EN
    last_edge = (edg_q == 2'd3);
    result    = cnt_q[CNT_W+1:2];
`else
    last_edge = 1'b1;
    result    = cnt_q;
`endif
  end

  // Next-state and datapath updates for the measurement FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    ovf_d    = ovf_q;
`ifdef FREQ_METER_AVG4_EN
    edg_d    = edg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (rise) begin
          state_d = MEAS;
          cnt_d   = ACC_ONE;
`ifdef FREQ_METER_AVG4_EN
          edg_d   = 2'd0;
`endif
        end else if (cnt_q == ACC_TOP) begin
          ovf_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ACC_ONE;
        end
      end
      MEAS: begin
        if (rise && last_edge) begin
          period_d = result;
          state_d  = DONE;
        end else if (cnt_q == ACC_MAX) begin
          ovf_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ACC_ONE;
`ifdef FREQ_METER_AVG4_EN
          if (rise) edg_d = edg_q + 2'd1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any measurement in flight
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      sync_q   <= '0;
      s_prev_q <= 1'b0;
`ifdef FREQ_METER_AVG4_EN
      edg_q    <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      sync_q   <= sync_d;
      s_prev_q <= s_prev_d;
`ifdef FREQ_METER_AVG4_EN
      edg_q    <= edg_d;
`endif
    end
  end

  assign period       = period_q;
  assign period_valid = (state_q == DONE);
  assign busy         = (state_q == ARM) || (state_q == MEAS);
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: drives square waves of known period into freq_meter
// and checks reported period, handshake pulses, timeout and reset.
module tb_freq_meter;

  localparam int CW = 8;
`ifdef FREQ_METER_AVG4_EN
  localparam int TO = (1 << (CW + 2)) - 1;
`else
  localparam int TO = (1 << CW) - 1;
`endif

  logic          CLK = 1'b0;
  logic          rst;
  logic          sig_in;
  logic          start;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int pat[4] = '{8, 8, 8, 8};
  bit gen_en = 1'b0;

  always #5 CLK = ~CLK;

  freq_meter #(
    .CNT_W(CW),
    .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .sig_in(sig_in),
    .start(start),
    .period(period),
    .period_valid(period_valid),
    .busy(busy),
    .overflow(overflow)
  );

  // Square-wave source: cycles through pat[], each entry one full period
  initial begin : gen
    int idx;
    int p;
    idx = 0;
    sig_in = 1'b0;
    forever begin
      if (!gen_en) begin
        sig_in = 1'b0;
        @(negedge CLK);
      end else begin
        p = pat[idx];
        idx = (idx + 1) % 4;
        sig_in = 1'b1;
        repeat (p / 2) @(negedge CLK);
        sig_in = 1'b0;
        repeat (p - p / 2) @(negedge CLK);
      end
    end
  end

  initial begin : watchdog
    #(10 * 80000);
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_wave(input int a, input int b, input int c, input int d);
    pat[0] = a;
    pat[1] = b;
    pat[2] = c;
    pat[3] = d;
    gen_en = 1'b1;
    repeat (100) @(negedge CLK);
  endtask

  task automatic run_meas(input string tag, input int exp_p, input bit restart);
    int nv;
    nv = 0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_ovf_start"}, 32'(overflow), 32'd0);
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      start = restart && (i == 2);
      if (period_valid) begin
        nv++;
        chk({tag, "_period"}, 32'(period), 32'(exp_p));
        chk({tag, "_busy_valid"}, 32'(busy), 32'd0);
      end else if (!busy) begin
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_finished"}, 32'(busy), 32'd0);
    repeat (10) begin
      @(negedge CLK);
      if (period_valid) nv++;
    end
    chk({tag, "_nvalid"}, 32'(nv), 32'd1);
    chk({tag, "_ovf_end"}, 32'(overflow), 32'd0);
  endtask

  initial begin : main
    int n;
    int nv;
    int p;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_valid", 32'(period_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    set_wave(8, 8, 8, 8);
    run_meas("p8", 8, 1'b0);

    set_wave(2, 2, 2, 2);
    run_meas("p2", 2, 1'b0);

    set_wave(8, 8, 8, 8);
    run_meas("p8_restart", 8, 1'b1);

    // Timeout: no edges at all
    gen_en = 1'b0;
    repeat (10) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n = 0;
    nv = 0;
    while (busy && n < 5000) begin
      n++;
      if (period_valid) nv++;
      @(negedge CLK);
    end
    chk("ovf_busy_cycles", 32'(n), 32'(TO));
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_busy_end", 32'(busy), 32'd0);
    chk("ovf_nvalid", 32'(nv + int'(period_valid)), 32'd0);
    chk("ovf_period_kept", 32'(period), 32'd8);
    set_wave(8, 8, 8, 8);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    run_meas("after_ovf", 8, 1'b0);

    // Reset in the middle of a measurement
    set_wave(10, 10, 10, 10);
    @(posedge sig_in);
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (8) @(negedge CLK);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    chk("mid_rst_period", 32'(period), 32'd0);
    chk("mid_rst_valid", 32'(period_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    nv = 0;
    repeat (60) begin
      @(negedge CLK);
      if (period_valid || busy) nv++;
    end
    chk("mid_rst_quiet", 32'(nv), 32'd0);
    run_meas("after_rst", 10, 1'b0);

    // Randomised periods and start phases
    for (int k = 0; k < 6; k++) begin
      p = int'($urandom_range(2, 40));
      set_wave(p, p, p, p);
      repeat ($urandom_range(0, p)) @(negedge CLK);
      run_meas($sformatf("rand%0d_p%0d", k, p), p, 1'b0);
    end

`ifdef FREQ_METER_AVG4_EN
    set_wave(8, 8, 9, 9);
    run_meas("avg_8899", 8, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
